// File: rtl/mux_pkg.sv
// Shared constants for the N-way selector family.
package mux_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_PRI = 1'b1;

  // Every bit of a reset/flushed data word takes this value.
  localparam logic RESET_BIT = 1'b0;

endpackage

// File: rtl/mux_n.sv
// Combinational N-way selector: encoded select or lowest-index priority request.
module mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       req,
  output logic [WIDTH-1:0]        data,
  output logic [SEL_W-1:0]        idx,
  output logic                    miss
);

  logic [WIDTH-1:0] words [NUM_IN];

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign words[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    idx  = '0;
    miss = 1'b0;
    if (mode == MODE_ENC) begin
      // Out-of-range codes only exist when NUM_IN is not a power of two.
      if (32'(sel) < NUM_IN) begin
        idx = sel;
      end else begin
        miss = 1'b1;
      end
    end else begin
      miss = ~|req;
      // Scan downward so the lowest requesting index is the last one written.
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx = SEL_W'(i);
        end
      end
    end
  end

  assign data = words[idx];

endmodule

// File: rtl/mux_n_reg.sv
// Pipeline-stage register around mux_n with stall hold, flush bubble and a
// saturating held-cycle counter.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       req,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic                    en,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_idx,
  output logic                    out_valid,
  output logic                    out_miss,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_miss;

  mux_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_mux (
    .in_data(in_data),
    .mode   (mode),
    .sel    (sel),
    .req    (req),
    .data   (sel_data),
    .idx    (sel_idx),
    .miss   (sel_miss)
  );

  logic [WIDTH-1:0] data_reg, data_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic             miss_reg, miss_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    data_next  = data_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    miss_next  = miss_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      data_next  = {WIDTH{RESET_BIT}};
      idx_next   = '0;
      valid_next = 1'b0;
      miss_next  = 1'b0;
      cnt_next   = '0;
    end else if (en) begin
      // Data is captured even for bubbles; out_valid only tags it.
      data_next  = sel_data;
      idx_next   = sel_idx;
      valid_next = in_valid;
      miss_next  = sel_miss;
      cnt_next   = '0;
    end else if (cnt_reg != {CNT_W{1'b1}}) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= {WIDTH{RESET_BIT}};
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      miss_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      data_reg  <= data_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      miss_reg  <= miss_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign out_data  = data_reg;
  assign out_idx   = idx_reg;
  assign out_valid = valid_reg;
  assign out_miss  = miss_reg;
  assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench: a 4-input and a 3-input instance share stimulus; expected
// outputs are queued at drive time and checked one cycle later by a monitor.
module tb_mux_n_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  req = 4'd0;
  logic [127:0] in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  logic [31:0] d4, d3;
  logic [1:0]  i4, i3;
  logic        v4, v3, m4, m3;
  logic [7:0]  c4, c3;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(32), .NUM_IN(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .req(req),
    .mode(mode), .in_valid(in_valid), .en(en), .flush(flush),
    .out_data(d4), .out_idx(i4), .out_valid(v4), .out_miss(m4), .stall_cnt(c4)
  );

  mux_n_reg #(.WIDTH(32), .NUM_IN(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel), .req(req[2:0]),
    .mode(mode), .in_valid(in_valid), .en(en), .flush(flush),
    .out_data(d3), .out_idx(i3), .out_valid(v3), .out_miss(m3), .stall_cnt(c3)
  );

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic [1:0]  i;
    logic        v;
    logic        m;
    logic [7:0]  c;
    logic [31:0] d3;
    logic [1:0]  i3;
    logic        m3;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t mk(string nm, logic [31:0] d, logic [1:0] i, logic v,
                              logic m, logic [7:0] c, logic [31:0] d3,
                              logic [1:0] i3, logic m3);
    exp_t x;
    x.nm = nm; x.d = d; x.i = i; x.v = v; x.m = m; x.c = c;
    x.d3 = d3; x.i3 = i3; x.m3 = m3;
    return x;
  endfunction

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endfunction

  task automatic apply(input logic rst, input logic fl, input logic e, input logic v,
                       input logic md, input logic [1:0] s, input logic [3:0] r,
                       input exp_t x);
    @(negedge clk);
    reset = rst; flush = fl; en = e; in_valid = v; mode = md; sel = s; req = r;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle after the edge, compare against the oldest expectation.
  initial begin
    forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        vectors++;
        chk(x.nm, "data4", d4, x.d);
        chk(x.nm, "idx4", 32'(i4), 32'(x.i));
        chk(x.nm, "valid4", 32'(v4), 32'(x.v));
        chk(x.nm, "miss4", 32'(m4), 32'(x.m));
        chk(x.nm, "cnt4", 32'(c4), 32'(x.c));
        chk(x.nm, "data3", d3, x.d3);
        chk(x.nm, "idx3", 32'(i3), 32'(x.i3));
        chk(x.nm, "valid3", 32'(v3), 32'(x.v));
        chk(x.nm, "miss3", 32'(m3), 32'(x.m3));
        chk(x.nm, "cnt3", 32'(c3), 32'(x.c));
        $display("vec %0d %s: d4=%h i4=%0d v=%b m4=%b cnt=%0d d3=%h i3=%0d m3=%b",
                 vectors, x.nm, d4, i4, v4, m4, c4, d3, i3, m3);
      end
    end
  end

  localparam logic [31:0] W0 = 32'h11111111;
  localparam logic [31:0] W1 = 32'h22222222;
  localparam logic [31:0] W2 = 32'h33333333;
  localparam logic [31:0] W3 = 32'h44444444;

  initial begin
    int budget;
    //     rst fl en v md sel req
    apply(1, 0, 1, 1, 0, 2'd2, 4'b0000, mk("reset", 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 0, 1, 1, 0, 2'd2, 4'b0000, mk("enc_sel2", W2, 2, 1, 0, 0, W2, 2, 0));
    apply(0, 0, 1, 1, 0, 2'd3, 4'b0000, mk("enc_sel3", W3, 3, 1, 0, 0, W0, 0, 1));
    apply(0, 0, 1, 1, 1, 2'd0, 4'b1010, mk("pri_1010", W1, 1, 1, 0, 0, W1, 1, 0));
    apply(0, 0, 1, 1, 1, 2'd0, 4'b0000, mk("pri_none", W0, 0, 1, 1, 0, W0, 0, 1));
    apply(0, 0, 1, 1, 1, 2'd1, 4'b1000, mk("pri_top", W3, 3, 1, 0, 0, W0, 0, 1));
    apply(0, 0, 1, 1, 1, 2'd3, 4'b0110, mk("pri_0110", W1, 1, 1, 0, 0, W1, 1, 0));
    apply(0, 0, 1, 0, 0, 2'd0, 4'b1111, mk("bubble_cap", W0, 0, 0, 0, 0, W0, 0, 0));
    apply(0, 0, 1, 1, 0, 2'd3, 4'b0000, mk("cap_sel3", W3, 3, 1, 0, 0, W0, 0, 1));
    // Long stall with churning select inputs: outputs hold, counter saturates.
    for (int k = 1; k <= 300; k++) begin
      logic [7:0] c;
      c = (k > 255) ? 8'd255 : 8'(k);
      apply(0, 0, 0, 0, k[0], 2'(k), 4'(k), mk("stall", W3, 3, 1, 0, c, W0, 0, 1));
    end
    apply(0, 0, 1, 1, 0, 2'd1, 4'b0000, mk("resume", W1, 1, 1, 0, 0, W1, 1, 0));
    apply(0, 1, 1, 1, 0, 2'd2, 4'b0000, mk("flush_en", 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 0, 1, 1, 0, 2'd2, 4'b0000, mk("cap_after_fl", W2, 2, 1, 0, 0, W2, 2, 0));
    for (int k = 1; k <= 5; k++)
      apply(0, 0, 0, 1, 0, 2'd0, 4'b0000, mk("short_stall", W2, 2, 1, 0, 8'(k), W2, 2, 0));
    apply(0, 1, 0, 1, 0, 2'd0, 4'b0000, mk("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 0, 1, 1, 0, 2'd1, 4'b0000, mk("cap_sel1", W1, 1, 1, 0, 0, W1, 1, 0));
    for (int k = 1; k <= 17; k++)
      apply(0, 0, 0, 1, 0, 2'd3, 4'b0000, mk("stall17", W1, 1, 1, 0, 8'(k), W1, 1, 0));
    apply(1, 0, 1, 1, 0, 2'd2, 4'b0000, mk("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 0, 1, 1, 0, 2'd2, 4'b0000, mk("post_reset", W2, 2, 1, 0, 0, W2, 2, 0));
    apply(0, 0, 1, 1, 1, 2'd0, 4'b0100, mk("post_pri", W2, 2, 1, 0, 0, W2, 2, 0));

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
